fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the PC register. It consumes the current PC, issues one instruction-memory read per instruction over a valid/ready request channel, and accepts the response on a valid-only response channel.
- It presents the fetched word and its PC to decode over a valid/ready handshake.
- It tells the PC register when to load nextPC, and discards in-flight fetches on a branch flush.

Parameters:
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction word width.
- CNT_W, 32, width of the delivered-instruction counter.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserting it immediately clears all state.
- pc_in  in  ADDR_W  current PC from the PC register.
- pc_advance  out  1  combinational; when 1, the PC register loads nextPC at the next edge.
- flush  in  1  branch/jump redirect; the PC register loads the target at the same edge.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  read address.
- imem_rsp_valid  in  1  read data valid, at least 1 cycle after acceptance.
- imem_rsp_data  in  DATA_W  read data.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst_data  out  DATA_W  instruction word.
- inst_pc  out  ADDR_W  address of inst_data.
- fetch_count  out  CNT_W  instructions delivered since reset.

Behaviour:
- States: IDLE, ISSUE, WAIT, HOLD, DRAIN. At most one request outstanding.
- Reset (reset=0, asynchronous):
  - state=IDLE; req_pc, inst_data, inst_pc, fetch_count = 0.
  - inst_valid, imem_req_valid, pc_advance = 0.
  - Any pending memory response is forgotten.
- IDLE: outputs inactive; go to ISSUE unconditionally next cycle.
- ISSUE: imem_req_valid=1, imem_req_addr=pc_in (combinational).
  - On imem_req_ready=1: req_pc<=pc_in, go to WAIT.
  - Otherwise stay in ISSUE.
- WAIT: imem_req_valid=0.
  - On imem_rsp_valid=1: inst_data<=imem_rsp_data, inst_pc<=req_pc, go to HOLD.
- HOLD: inst_valid=1; inst_data and inst_pc stay stable until the handshake.
  - On inst_valid&inst_ready: pc_advance=1 in that cycle, fetch_count<=fetch_count+1 (wraps at 2^CNT_W), go to ISSUE.
  - Next request address is the updated pc_in.
- DRAIN: wait for imem_rsp_valid, discard the data, go to ISSUE. No inst_valid and no count increment.
- Flush has priority over every other event in the same cycle:
  - pc_advance is forced to 0.
  - ISSUE, request accepted in the flush cycle: go to DRAIN (stale address).
  - ISSUE, not accepted: stay in ISSUE. The request may be retracted or readdressed; the next cycle presents the new pc_in.
  - WAIT, imem_rsp_valid=1 in the same cycle: discard the data, go to ISSUE.
  - WAIT, no response: go to DRAIN.
  - HOLD: drop inst_valid, no count increment even if inst_ready=1, go to ISSUE.
  - DRAIN or IDLE: no change.
- Responses arriving in IDLE, ISSUE or HOLD are a protocol violation and are ignored.
- Throughput: minimum 3 cycles per instruction (ISSUE accepted, 1-cycle response, HOLD consumed). Each extra cycle of req_ready, rsp or inst_ready delay adds 1 cycle.
- imem_req_addr is don't-care when imem_req_valid=0; the bench must not check it.

Test Plan:
- Reset release, pc_in=0x0, req_ready=1, 1-cycle response 0x00500093, inst_ready=1 → IDLE, ISSUE at cycle 1, addr 0x0. inst_valid with inst_data=0x00500093, inst_pc=0x0 at cycle 3; pc_advance=1 that cycle; fetch_count=1.
- Back-to-back with pc_in stepping 0x0, 0x4, 0x8 → three requests, inst_pc 0x0/0x4/0x8 in order, one pc_advance per delivery, fetch_count=3.
- Backpressure: inst_ready=0 for 4 cycles in HOLD → inst_data/inst_pc stable, no new request, pc_advance=0; first ready cycle completes the handshake.
- Flush in WAIT (no response), then response 0xDEADBEEF arrives, pc_in=0x100 → 0xDEADBEEF never shown on inst_data. Next request addr=0x100; fetch_count unchanged.
- Flush in HOLD with inst_ready=1 → no delivery, pc_advance=0, fetch_count unchanged, next state ISSUE.
- reset=0 asserted mid-WAIT → outputs cleared immediately without waiting for an edge; on release the first request is at the current pc_in.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundles the fetch stage's instruction-memory and decode channels.
// The master is the fetch unit; the slave side is memory plus decode.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, holds the fetched word for
// decode, advances the PC on delivery and discards in-flight reads on flush.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              flush,
  fetch_unit_if.master      bus,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
  logic              req_valid;
  logic              inst_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      req_pc_q      <= '0;
      inst_data_q   <= '0;
      inst_pc_q     <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      inst_data_q   <= inst_data_d;
      inst_pc_q     <= inst_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    inst_data_d   = inst_data_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;
    req_valid     = 1'b0;
    inst_valid    = 1'b0;
    pc_advance    = 1'b0;

    unique case (state_q)
      IDLE: state_d = ISSUE;

      ISSUE: begin
        req_valid = 1'b1;
        if (bus.imem_req_ready) begin
          req_pc_d = pc_in;
          // An accepted request carrying a pre-redirect address must be drained.
          state_d  = flush ? DRAIN : WAIT;
        end
      end

      WAIT: begin
        if (flush) begin
          state_d = bus.imem_rsp_valid ? ISSUE : DRAIN;
        end else if (bus.imem_rsp_valid) begin
          inst_data_d = bus.imem_rsp_data;
          inst_pc_d   = req_pc_q;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        // Valid drops during a flush so decode can never complete a handshake on it.
        inst_valid = !flush;
        if (flush) begin
          state_d = ISSUE;
        end else if (bus.inst_ready) begin
          pc_advance    = 1'b1;
          fetch_count_d = fetch_count_q + CNT_W'(1);
          state_d       = ISSUE;
        end
      end

      DRAIN: begin
        if (bus.imem_rsp_valid) state_d = ISSUE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_in;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst_data      = inst_data_q;
  assign bus.inst_pc        = inst_pc_q;
  assign fetch_count        = fetch_count_q;

endmodule
